// File: rtl/bht_access_ctrl.sv
// Single-port BHT arbiter: post-reset table init, fetch lookups and
// FIFO-buffered commit updates applied as 2-bit counter read-modify-writes.
module bht_access_ctrl #(
    parameter int IDX_W     = 8,
    parameter int UPD_DEPTH = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              lookup_valid_in,
    input  logic [ADDR_W-1:0] lookup_pc_in,
    output logic              lookup_ready_out,
    output logic              pred_valid_out,
    output logic              pred_taken_out,
    input  logic              flush_in,
    input  logic              upd_valid_in,
    input  logic [ADDR_W-1:0] upd_pc_in,
    input  logic              upd_taken_in,
    output logic              upd_ready_out,
    output logic              tbl_en_out,
    output logic              tbl_we_out,
    output logic [IDX_W-1:0]  tbl_addr_out,
    output logic [1:0]        tbl_wdata_out,
    input  logic [1:0]        tbl_rdata_in,
    output logic              init_done_out
);
    localparam int PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(UPD_DEPTH);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_UPD_WR} state_e;

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                init_ptr_q, init_ptr_d;
    logic                            init_done_q, init_done_d;
    logic [UPD_DEPTH-1:0][IDX_W-1:0] fifo_idx_q;
    logic [UPD_DEPTH-1:0]            fifo_tkn_q;
    logic [PTR_W-1:0]                wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]                count_q;
    logic [IDX_W-1:0]                rmw_idx_q;
    logic                            rmw_tkn_q;
    logic                            rd_capt_q;
    logic [1:0]                      rdata_q;
    logic                            pending_q;

    logic             pop, enq, lk_acc;
    logic [1:0]       rdata_cur;
    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic             unused_pc;

    assign lk_idx    = lookup_pc_in[IDX_W+1:2];
    assign upd_idx   = upd_pc_in[IDX_W+1:2];
    assign unused_pc = ^{lookup_pc_in[ADDR_W-1:IDX_W+2], lookup_pc_in[1:0],
                         upd_pc_in[ADDR_W-1:IDX_W+2], upd_pc_in[1:0]};

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
        else   return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Read data is only on the bus the cycle after the read; a stalled
    // write phase falls back to the copy latched at that point.
    assign rdata_cur = rd_capt_q ? tbl_rdata_in : rdata_q;

    always_comb begin
        state_d          = state_q;
        init_ptr_d       = init_ptr_q;
        init_done_d      = init_done_q;
        pop              = 1'b0;
        lk_acc           = 1'b0;
        lookup_ready_out = 1'b0;
        tbl_en_out       = 1'b0;
        tbl_we_out       = 1'b0;
        tbl_addr_out     = '0;
        tbl_wdata_out    = 2'b00;
        if (rst_in && rdy_in) begin
            unique case (state_q)
                S_INIT: begin
                    tbl_en_out    = 1'b1;
                    tbl_we_out    = 1'b1;
                    tbl_addr_out  = init_ptr_q;
                    tbl_wdata_out = 2'b01;
                    init_ptr_d    = init_ptr_q + 1'b1;
                    if (init_ptr_q == {IDX_W{1'b1}}) begin
                        state_d     = S_RUN;
                        init_done_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (count_q == FULL_CNT || (count_q != '0 && !lookup_valid_in)) begin
                        pop          = 1'b1;
                        tbl_en_out   = 1'b1;
                        tbl_addr_out = fifo_idx_q[rd_ptr_q];
                        state_d      = S_UPD_WR;
                    end else begin
                        lookup_ready_out = 1'b1;
                        if (lookup_valid_in) begin
                            lk_acc       = 1'b1;
                            tbl_en_out   = 1'b1;
                            tbl_addr_out = lk_idx;
                        end
                    end
                end
                S_UPD_WR: begin
                    tbl_en_out    = 1'b1;
                    tbl_we_out    = 1'b1;
                    tbl_addr_out  = rmw_idx_q;
                    tbl_wdata_out = sat(rdata_cur, rmw_tkn_q);
                    state_d       = S_RUN;
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    assign upd_ready_out  = rst_in & rdy_in & (count_q < FULL_CNT);
    assign enq            = upd_valid_in & upd_ready_out;
    assign pred_valid_out = pending_q & ~flush_in;
    assign pred_taken_out = pred_valid_out & tbl_rdata_in[1];
    assign init_done_out  = init_done_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_INIT;
            init_ptr_q  <= '0;
            init_done_q <= 1'b0;
            fifo_idx_q  <= '0;
            fifo_tkn_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rmw_idx_q   <= '0;
            rmw_tkn_q   <= 1'b0;
            rd_capt_q   <= 1'b0;
            rdata_q     <= 2'b00;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            init_done_q <= init_done_d;
            rd_capt_q   <= tbl_en_out & ~tbl_we_out;
            pending_q   <= lk_acc & ~flush_in;
            if (rd_capt_q) rdata_q <= tbl_rdata_in;
            if (enq) begin
                fifo_idx_q[wr_ptr_q] <= upd_idx;
                fifo_tkn_q[wr_ptr_q] <= upd_taken_in;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rmw_idx_q <= fifo_idx_q[rd_ptr_q];
                rmw_tkn_q <= fifo_tkn_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(enq) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_bht_access_ctrl.sv
// Directed bench for bht_access_ctrl with a behavioural single-port table.
module tb_bht_access_ctrl;
    localparam int IDX_W = 8, UPD_DEPTH = 4, ADDR_W = 32;

    logic              clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b0;
    logic              lookup_valid_in = 1'b0, flush_in = 1'b0;
    logic              upd_valid_in = 1'b0, upd_taken_in = 1'b0;
    logic [ADDR_W-1:0] lookup_pc_in = '0, upd_pc_in = '0;
    logic              lookup_ready_out, pred_valid_out, pred_taken_out, upd_ready_out;
    logic              tbl_en_out, tbl_we_out, init_done_out;
    logic [IDX_W-1:0]  tbl_addr_out;
    logic [1:0]        tbl_wdata_out;
    logic [1:0]        tbl_rdata_in = 2'b00;
    logic [1:0]        mem [256];
    int                n_chk = 0, n_fail = 0;

    bht_access_ctrl #(.IDX_W(IDX_W), .UPD_DEPTH(UPD_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .lookup_valid_in(lookup_valid_in), .lookup_pc_in(lookup_pc_in),
        .lookup_ready_out(lookup_ready_out), .pred_valid_out(pred_valid_out),
        .pred_taken_out(pred_taken_out), .flush_in(flush_in),
        .upd_valid_in(upd_valid_in), .upd_pc_in(upd_pc_in), .upd_taken_in(upd_taken_in),
        .upd_ready_out(upd_ready_out), .tbl_en_out(tbl_en_out), .tbl_we_out(tbl_we_out),
        .tbl_addr_out(tbl_addr_out), .tbl_wdata_out(tbl_wdata_out),
        .tbl_rdata_in(tbl_rdata_in), .init_done_out(init_done_out)
    );

    always #5 clk_in = ~clk_in;

    // Read data is only valid the cycle after a read; otherwise the bus reads 00.
    always @(posedge clk_in) begin
        tbl_rdata_in <= 2'b00;
        if (tbl_en_out) begin
            if (tbl_we_out) mem[tbl_addr_out] <= tbl_wdata_out;
            else            tbl_rdata_in <= mem[tbl_addr_out];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic lr, input logic done, input logic en,
                                       input logic we, input logic [7:0] a, input logic [1:0] wd);
        return {18'b0, lr, done, en, we, a, wd};
    endfunction

    function automatic logic [31:0] obs();
        return {18'b0, lookup_ready_out, init_done_out, tbl_en_out, tbl_we_out,
                tbl_addr_out, tbl_wdata_out};
    endfunction

    // Entered at negedge+1 right after reset release; ends at the first RUN cycle.
    task automatic run_init(input int pause_at);
        for (int i = 0; i < 256; i++) begin
            if (i == pause_at) begin
                rdy_in = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    chk("pause_idle", {upd_ready_out, obs()}, {1'b0, mk(0, 0, 0, 0, 0, 0)});
                    @(negedge clk_in);
                end
                rdy_in = 1'b1;
                #1;
            end
            chk("init_wr", obs(), mk(0, 0, 1, 1, 8'(i), 2'b01));
            @(negedge clk_in); #1;
        end
        chk("init_done", obs(), mk(1, 1, 0, 0, 0, 0));
    endtask

    task automatic do_lookup(input logic [31:0] pc, input logic [7:0] a, input logic tkn);
        @(negedge clk_in); lookup_valid_in = 1'b1; lookup_pc_in = pc; #1;
        chk("lk_issue", obs(), mk(1, 1, 1, 0, a, 0));
        @(negedge clk_in); lookup_valid_in = 1'b0; #1;
        chk("lk_resp", {pred_valid_out, pred_taken_out}, {1'b1, tkn});
        @(negedge clk_in); #1;
        chk("lk_pulse", pred_valid_out, 0);
    endtask

    task automatic do_update(input logic [31:0] pc, input logic tkn, input logic [7:0] a,
                             input logic [1:0] exp_w, input logic stall);
        @(negedge clk_in); upd_valid_in = 1'b1; upd_pc_in = pc; upd_taken_in = tkn; #1;
        chk("upd_enq", {upd_ready_out, obs()}, {1'b1, mk(1, 1, 0, 0, 0, 0)});
        @(negedge clk_in); upd_valid_in = 1'b0; #1;
        chk("rmw_rd", obs(), mk(0, 1, 1, 0, a, 0));
        @(negedge clk_in);
        if (stall) begin
            rdy_in = 1'b0; #1;
            chk("rmw_stall", obs(), mk(0, 1, 0, 0, 0, 0));
            @(negedge clk_in); rdy_in = 1'b1;
        end
        #1;
        chk("rmw_wr", obs(), mk(0, 1, 1, 1, a, exp_w));
    endtask

    initial begin
        rdy_in = 1'b1;
        @(negedge clk_in); #1;
        chk("rst_out", {upd_ready_out, pred_valid_out, pred_taken_out, obs()}, 0);
        @(negedge clk_in); rst_in = 1'b1; #1;
        run_init(16);

        do_lookup(32'h104, 8'h41, 1'b0);
        do_update(32'h104, 1'b1, 8'h41, 2'b10, 1'b0);
        do_update(32'h104, 1'b1, 8'h41, 2'b11, 1'b1);
        do_update(32'h104, 1'b1, 8'h41, 2'b11, 1'b0);
        do_lookup(32'h104, 8'h41, 1'b1);
        do_update(32'h104, 1'b0, 8'h41, 2'b10, 1'b0);
        do_update(32'h104, 1'b0, 8'h41, 2'b01, 1'b0);
        do_update(32'h104, 1'b0, 8'h41, 2'b00, 1'b0);
        do_lookup(32'h104, 8'h41, 1'b0);

        // Continuous lookups while four updates fill the FIFO.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            lookup_valid_in = 1'b1; lookup_pc_in = 32'h200;
            upd_valid_in = 1'b1; upd_pc_in = 32'h10 + 32'(4 * k); upd_taken_in = 1'b1; #1;
            chk("fill_lk", {upd_ready_out, pred_valid_out, obs()},
                {1'b1, (k > 0), mk(1, 1, 1, 0, 8'h80, 0)});
        end
        @(negedge clk_in); upd_valid_in = 1'b0; #1;
        chk("full_pop", {upd_ready_out, pred_valid_out, obs()}, {1'b0, 1'b1, mk(0, 1, 1, 0, 8'h04, 0)});
        @(negedge clk_in); #1;
        chk("full_wr", {upd_ready_out, pred_valid_out, obs()}, {1'b1, 1'b0, mk(0, 1, 1, 1, 8'h04, 2'b10)});
        @(negedge clk_in); #1;
        chk("lk_resume", {upd_ready_out, pred_valid_out, obs()}, {1'b1, 1'b0, mk(1, 1, 1, 0, 8'h80, 0)});
        @(negedge clk_in); lookup_valid_in = 1'b0; #1;
        chk("drain_rd", {pred_valid_out, pred_taken_out, obs()}, {1'b1, 1'b0, mk(0, 1, 1, 0, 8'h05, 0)});
        for (int k = 0; k < 6; k++) @(negedge clk_in);
        #1;
        chk("drained", {upd_ready_out, obs()}, {1'b1, mk(1, 1, 0, 0, 0, 0)});
        do_lookup(32'h1C, 8'h07, 1'b1);

        // Flush one cycle after acceptance, then flush in the acceptance cycle.
        @(negedge clk_in); lookup_valid_in = 1'b1; lookup_pc_in = 32'h104; #1;
        chk("fl_acc", obs(), mk(1, 1, 1, 0, 8'h41, 0));
        @(negedge clk_in); lookup_valid_in = 1'b0; flush_in = 1'b1; #1;
        chk("fl_kill", pred_valid_out, 0);
        @(negedge clk_in); flush_in = 1'b0; #1;
        chk("fl_late", pred_valid_out, 0);
        @(negedge clk_in); lookup_valid_in = 1'b1; flush_in = 1'b1; #1;
        chk("fl0_acc", lookup_ready_out, 1);
        @(negedge clk_in); lookup_valid_in = 1'b0; flush_in = 1'b0; #1;
        chk("fl0_kill", pred_valid_out, 0);

        // Reset landing in the write phase of an RMW.
        @(negedge clk_in); upd_valid_in = 1'b1; upd_pc_in = 32'h104; upd_taken_in = 1'b1;
        @(negedge clk_in); upd_valid_in = 1'b0; #1;
        chk("rr_rd", obs(), mk(0, 1, 1, 0, 8'h41, 0));
        @(negedge clk_in); rst_in = 1'b0; #1;
        chk("rr_abort", {upd_ready_out, obs()}, 0);
        @(negedge clk_in); rst_in = 1'b1; #1;
        run_init(-1);
        do_lookup(32'h104, 8'h41, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
